// File: rtl/stg5wb.sv
// Write-back stage: commits results to GP/SR files, bypassed read ports, retire counter, halt latch.
// Latency: reads are combinational with same-cycle bypass; retire count, halt and trace outputs are registered (1 cycle).
// Backpressure: none; every cycle carries one instruction (or a NOP bubble), and HALTED freezes all commits.
//
// Ports:
//   iw_clk, iw_rst_n            clock, async active-low reset
//   iw_pc/iw_opc/iw_result      instruction in stage 5
//   iw_tgt_gp(_we), iw_tgt_sr(_we)  write targets
//   iw_rd_a/b_addr -> ow_rd_a/b GP read ports (bypassed)
//   iw_sr_addr -> ow_sr         SR read port (bypassed, out-of-range reads 0)
//   ow_retired, ow_halted       retire count and halted flag
//   ow_trc_valid/pc/data        retirement trace (only when DIAD_WB_TRACE_EN is defined; tied to 0 otherwise)
`timescale 1ns/1ps

`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 3
`endif

module stg5wb #(
    parameter int                   GP_REGS  = 16,
    parameter int                   SR_REGS  = 4,
    parameter logic [`SIZE_OPC-1:0] OPC_NOP  = '0,
    parameter logic [`SIZE_OPC-1:0] OPC_HALT = '1,
    parameter int                   ZERO_R0  = 1
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst_n,
    input  logic [`SIZE_ADDR-1:0]   iw_pc,
    input  logic [`SIZE_OPC-1:0]    iw_opc,
    input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic                    iw_tgt_gp_we,
    input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic                    iw_tgt_sr_we,
    input  logic [`SIZE_DATA-1:0]   iw_result,
    input  logic [`SIZE_TGT_GP-1:0] iw_rd_a_addr,
    input  logic [`SIZE_TGT_GP-1:0] iw_rd_b_addr,
    output logic [`SIZE_DATA-1:0]   ow_rd_a,
    output logic [`SIZE_DATA-1:0]   ow_rd_b,
    input  logic [`SIZE_TGT_SR-1:0] iw_sr_addr,
    output logic [`SIZE_DATA-1:0]   ow_sr,
    output logic [`SIZE_DATA-1:0]   ow_retired,
    output logic                    ow_halted,
    output logic                    ow_trc_valid,
    output logic [`SIZE_ADDR-1:0]   ow_trc_pc,
    output logic [`SIZE_DATA-1:0]   ow_trc_data
);

    localparam int SR_IW = (SR_REGS > 1) ? $clog2(SR_REGS) : 1;

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [`SIZE_DATA-1:0]   r_gp [GP_REGS];
    logic [`SIZE_DATA-1:0]   r_sr [SR_REGS];
    logic [`SIZE_DATA-1:0]   r_retired;

    logic                    w_run;
    logic                    w_gp_we;
    logic                    w_sr_we;
    logic                    w_count;
    logic                    w_sr_wr_ok;
    logic                    w_sr_rd_ok;
    logic [SR_IW-1:0]        w_sr_wi;
    logic [SR_IW-1:0]        w_sr_ri;

    // Narrow SR indices to the array's index width; range checks use the full index.
    assign w_sr_wi    = iw_tgt_sr[SR_IW-1:0];
    assign w_sr_ri    = iw_sr_addr[SR_IW-1:0];
    assign w_sr_wr_ok = (32'(iw_tgt_sr) < SR_REGS);
    assign w_sr_rd_ok = (32'(iw_sr_addr) < SR_REGS);
    assign w_run      = (r_state == ST_RUN);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) r_state <= ST_RUN;
        else           r_state <= w_state_nxt;
    end

    // Next state and commit enables; HALT's own writes and count still go through.
    always_comb begin
        w_state_nxt = r_state;
        w_gp_we     = 1'b0;
        w_sr_we     = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_gp_we = iw_tgt_gp_we && !((ZERO_R0 != 0) && (iw_tgt_gp == '0));
                w_sr_we = iw_tgt_sr_we && w_sr_wr_ok;
                w_count = (iw_opc != OPC_NOP);
                if (iw_opc == OPC_HALT) w_state_nxt = ST_HALTED;
            end
            default: w_state_nxt = ST_HALTED;
        endcase
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < GP_REGS; i++) r_gp[i] <= '0;
            for (int i = 0; i < SR_REGS; i++) r_sr[i] <= '0;
            r_retired <= '0;
        end else begin
            if (w_gp_we) r_gp[iw_tgt_gp] <= iw_result;
            if (w_sr_we) r_sr[w_sr_wi]   <= iw_result;
            if (w_count) r_retired       <= r_retired + 1'b1;
        end
    end

    // Read ports: hardwired zero first, then same-cycle bypass of the commit, then the file.
    assign ow_rd_a = ((ZERO_R0 != 0) && (iw_rd_a_addr == '0)) ? '0 :
                     (w_run && iw_tgt_gp_we && (iw_tgt_gp == iw_rd_a_addr)) ? iw_result :
                     r_gp[iw_rd_a_addr];
    assign ow_rd_b = ((ZERO_R0 != 0) && (iw_rd_b_addr == '0)) ? '0 :
                     (w_run && iw_tgt_gp_we && (iw_tgt_gp == iw_rd_b_addr)) ? iw_result :
                     r_gp[iw_rd_b_addr];
    assign ow_sr   = !w_sr_rd_ok ? '0 :
                     (w_run && iw_tgt_sr_we && (iw_tgt_sr == iw_sr_addr)) ? iw_result :
                     r_sr[w_sr_ri];

    assign ow_retired = r_retired;
    assign ow_halted  = (r_state == ST_HALTED);

`ifdef DIAD_WB_TRACE_EN
    logic                  r_trc_valid;
    logic [`SIZE_ADDR-1:0] r_trc_pc;
    logic [`SIZE_DATA-1:0] r_trc_data;

    // Trace strobes once per counted retirement; payload holds until the next one.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_trc_valid <= 1'b0;
            r_trc_pc    <= '0;
            r_trc_data  <= '0;
        end else begin
            r_trc_valid <= w_count;
            if (w_count) begin
                r_trc_pc   <= iw_pc;
                r_trc_data <= iw_result;
            end
        end
    end

    assign ow_trc_valid = r_trc_valid;
    assign ow_trc_pc    = r_trc_pc;
    assign ow_trc_data  = r_trc_data;
`else
    logic w_unused_pc;
    assign w_unused_pc  = ^iw_pc;
    assign ow_trc_valid = 1'b0;
    assign ow_trc_pc    = '0;
    assign ow_trc_data  = '0;
`endif

endmodule

// File: tb/tb_stg5wb.sv
// Scoreboard bench for stg5wb: driver applies one instruction per cycle, pushes the
// expected outputs from a register-file model, and a monitor compares them.
`timescale 1ns/1ps

module tb_stg5wb;

    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] HALT = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pc;
    logic [5:0]  opc;
    logic [3:0]  tgt_gp;
    logic        gp_we;
    logic [2:0]  tgt_sr;
    logic        sr_we;
    logic [23:0] result;
    logic [3:0]  ra, rb;
    logic [2:0]  sa;
    logic [23:0] rd_a, rd_b, sr_o, retired, trc_pc, trc_data;
    logic        halted, trc_valid;

    always #5 clk = ~clk;

    stg5wb dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_pc(pc), .iw_opc(opc),
        .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we), .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we),
        .iw_result(result), .iw_rd_a_addr(ra), .iw_rd_b_addr(rb), .ow_rd_a(rd_a), .ow_rd_b(rd_b),
        .iw_sr_addr(sa), .ow_sr(sr_o), .ow_retired(retired), .ow_halted(halted),
        .ow_trc_valid(trc_valid), .ow_trc_pc(trc_pc), .ow_trc_data(trc_data)
    );

    typedef struct packed {
        logic [23:0] rd_a, rd_b, sr, ret;
        logic        halted, trc_v;
        logic [23:0] trc_pc, trc_d;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    // Reference model state
    logic [23:0] m_gp [16];
    logic [23:0] m_sr [4];
    logic [23:0] m_cnt;
    bit          m_halt;
    bit          m_tv;
    logic [23:0] m_tpc, m_td;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gp[i] = '0;
        for (int i = 0; i < 4; i++)  m_sr[i] = '0;
        m_cnt = '0; m_halt = 0; m_tv = 0; m_tpc = '0; m_td = '0;
    endtask

    function automatic logic [23:0] gp_read(input logic [3:0] a);
        if (a == 0) return '0;
        if (!m_halt && gp_we && tgt_gp == a) return result;
        return m_gp[a];
    endfunction

    function automatic logic [23:0] sr_read(input logic [2:0] a);
        if (a >= 3'd4) return '0;
        if (!m_halt && sr_we && tgt_sr == a) return result;
        return m_sr[a[1:0]];
    endfunction

    // One instruction per cycle: drive at negedge, record expectation, advance model.
    task automatic step(input logic [23:0] i_pc, input logic [5:0] i_opc,
                        input logic [3:0] i_tg, input logic i_gwe,
                        input logic [2:0] i_ts, input logic i_swe, input logic [23:0] i_res,
                        input logic [3:0] i_ra, input logic [3:0] i_rb, input logic [2:0] i_sa,
                        input bit preload_max);
        exp_t e;
        @(negedge clk);
        if (preload_max) begin
            dut.r_retired = 24'hFFFFFF;
            m_cnt = 24'hFFFFFF;
        end
        pc = i_pc; opc = i_opc; tgt_gp = i_tg; gp_we = i_gwe; tgt_sr = i_ts; sr_we = i_swe;
        result = i_res; ra = i_ra; rb = i_rb; sa = i_sa;
        e.rd_a = gp_read(i_ra);
        e.rd_b = gp_read(i_rb);
        e.sr   = sr_read(i_sa);
        e.ret  = m_cnt;
        e.halted = m_halt;
`ifdef DIAD_WB_TRACE_EN
        e.trc_v = m_tv; e.trc_pc = m_tpc; e.trc_d = m_td;
`else
        e.trc_v = 1'b0; e.trc_pc = '0; e.trc_d = '0;
`endif
        q.push_back(e);
        if (!m_halt) begin
            if (i_gwe && i_tg != 0) m_gp[i_tg] = i_res;
            if (i_swe && i_ts < 3'd4) m_sr[i_ts[1:0]] = i_res;
            if (i_opc != NOP) begin
                m_cnt = m_cnt + 24'd1;
                m_tv = 1; m_tpc = i_pc; m_td = i_res;
            end else begin
                m_tv = 0;
            end
            if (i_opc == HALT) m_halt = 1;
        end else begin
            m_tv = 0;
        end
    endtask

    task automatic rand_step(input bit allow_halt);
        logic [5:0]  o;
        logic [3:0]  t;
        logic [2:0]  ts;
        logic [23:0] r;
        o  = ($urandom_range(0, 3) == 0) ? NOP : 6'($urandom_range(1, 62));
        if (allow_halt && $urandom_range(0, 60) == 0) o = HALT;
        t  = 4'($urandom_range(0, 15));
        ts = 3'($urandom_range(0, 7));
        r  = 24'($urandom);
        step(24'($urandom), o, t, 1'($urandom_range(0, 1)), ts, 1'($urandom_range(0, 1)), r,
             ($urandom_range(0, 1) != 0) ? t : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) != 0) ? ts : 3'($urandom_range(0, 7)), 0);
    endtask

    // Asynchronous reset mid-cycle with a write pending; that write must be lost.
    task automatic do_reset();
        @(negedge clk);
        pc = 24'h1; opc = 6'd5; tgt_gp = 4'd3; gp_we = 1; tgt_sr = 3'd1; sr_we = 1;
        result = 24'hDEAD01;
        #1 rst_n = 0;
        model_reset();
        @(negedge clk);
        gp_we = 0; sr_we = 0; opc = NOP;
        #1 rst_n = 1;
    endtask

    // Monitor: compares the oldest expectation away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_a", rd_a, e.rd_a);
                chk("rd_b", rd_b, e.rd_b);
                chk("sr", sr_o, e.sr);
                chk("retired", retired, e.ret);
                chk("halted", {23'd0, halted}, {23'd0, e.halted});
                chk("trc_valid", {23'd0, trc_valid}, {23'd0, e.trc_v});
                chk("trc_pc", trc_pc, e.trc_pc);
                chk("trc_data", trc_data, e.trc_d);
            end
        end
    end

    initial begin
        rst_n = 0; pc = '0; opc = NOP; tgt_gp = '0; gp_we = 0; tgt_sr = '0; sr_we = 0;
        result = '0; ra = '0; rb = '0; sa = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Reset state: every GP address reads 0
        for (int i = 0; i < 16; i++)
            step(0, NOP, 0, 0, 0, 0, 0, 4'(i), 4'(15 - i), 3'(i % 8), 0);

        // Bypass then persistence of gp[5]
        step(24'h10, 6'd1, 4'd5, 1, 0, 0, 24'h00A5A5, 4'd5, 4'd0, 0, 0);
        repeat (3) step(0, NOP, 0, 0, 0, 0, 0, 4'd5, 4'd5, 0, 0);

        // Writes to r0 are ignored but still retire
        step(24'h14, 6'd2, 4'd0, 1, 0, 0, 24'h123456, 4'd0, 4'd0, 0, 0);
        step(0, NOP, 0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0);

        // SR writes: in-range, out-of-range, and concurrent with a GP write
        step(24'h18, 6'd3, 4'd7, 1, 3'd2, 1, 24'h0000BB, 4'd7, 4'd7, 3'd2, 0);
        step(24'h1C, 6'd3, 4'd8, 0, 3'd6, 1, 24'h0000CC, 4'd7, 4'd8, 3'd6, 0);
        step(0, NOP, 0, 0, 0, 0, 0, 4'd7, 4'd8, 3'd2, 0);

        // Counter wrap from all-ones
        step(24'h20, 6'd4, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Trace payload for a known retirement followed by a NOP
        step(24'h000040, 6'd9, 4'd9, 1, 0, 0, 24'h000099, 4'd9, 0, 0, 0);
        step(0, NOP, 0, 0, 0, 0, 0, 4'd9, 0, 0, 0);
        step(0, NOP, 0, 0, 0, 0, 0, 4'd9, 0, 0, 0);

        repeat (300) rand_step(0);

        // Halt sequence from a clean count
        do_reset();
        repeat (3) step(24'h100, 6'd7, 4'd4, 1, 3'd0, 1, 24'h000044, 4'd4, 4'd2, 3'd0, 0);
        repeat (2) step(0, NOP, 4'd6, 0, 0, 0, 0, 4'd4, 4'd2, 0, 0);
        step(24'h10C, HALT, 4'd2, 1, 3'd1, 1, 24'd7, 4'd2, 4'd2, 3'd1, 0);
        for (int i = 0; i < 4; i++)
            step(24'h110, 6'd8, 4'(10 + i), 1, 3'd3, 1, 24'h5A5A00 + 24'(i), 4'(10 + i), 4'd2, 3'd3, 0);
        repeat (2) step(0, NOP, 0, 0, 0, 0, 0, 4'd2, 4'd10, 3'd1, 0);
        #2;
        chk("retired_frozen_at_halt", retired, 24'd4);
        chk("halted_latched", {23'd0, halted}, 24'd1);

        do_reset();
        repeat (300) rand_step(1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/stg5wb.md
Name: stg5wb

Overview:
Pipeline stage 5 (write-back). Consumes the registered outputs of the stage-4 memory-operation stage.
- Commits results into the general-purpose (GP) register file and the special-register (SR) file.
- Exposes two GP read ports, with same-cycle write bypass, to the decode stage.
- Counts retired instructions and latches a halted state on the HALT opcode.

Parameters:
GP_REGS, 16, number of GP registers; must equal 2**`SIZE_TGT_GP
SR_REGS, 4, number of SRs; must be ≤ 2**`SIZE_TGT_SR
OPC_NOP, 0, bubble opcode; never counted as retired
OPC_HALT, all-ones of `SIZE_OPC, halt opcode
ZERO_R0, 1, when 1, GP register 0 reads as 0 and ignores writes

Ports:
iw_clk  in  1  clock; all state updates on rising edge
iw_rst_n  in  1  reset, asynchronous assert, active-low
iw_pc  in  `SIZE_ADDR  PC of instruction in stage 5
iw_opc  in  `SIZE_OPC  opcode
iw_tgt_gp  in  `SIZE_TGT_GP  GP target index
iw_tgt_gp_we  in  1  GP write enable
iw_tgt_sr  in  `SIZE_TGT_SR  SR target index
iw_tgt_sr_we  in  1  SR write enable
iw_result  in  `SIZE_DATA  value to commit
iw_rd_a_addr  in  `SIZE_TGT_GP  read port A index
iw_rd_b_addr  in  `SIZE_TGT_GP  read port B index
ow_rd_a  out  `SIZE_DATA  read port A data (combinational)
ow_rd_b  out  `SIZE_DATA  read port B data (combinational)
iw_sr_addr  in  `SIZE_TGT_SR  SR read index
ow_sr  out  `SIZE_DATA  SR read data (combinational, bypassed)
ow_retired  out  `SIZE_DATA  retired-instruction count
ow_halted  out  1  1 once HALT has retired
ow_trc_valid  out  1  trace strobe (optional feature)
ow_trc_pc  out  `SIZE_ADDR  traced PC
ow_trc_data  out  `SIZE_DATA  traced result

Behaviour:
- Reset (iw_rst_n=0, asynchronous):
  - All GP and SR entries cleared to 0.
  - ow_retired=0, state RUN, ow_halted=0.
  - Trace outputs cleared to 0.
  - Reset asserted mid-operation discards any write in flight that cycle.
- FSM states: RUN and HALTED.
  - RUN→HALTED on a rising edge where iw_opc==OPC_HALT.
  - HALTED is left only by reset.
- Commit, on a rising edge in RUN:
  - If iw_tgt_gp_we, then gp[iw_tgt_gp] <= iw_result. Suppressed when ZERO_R0=1 and iw_tgt_gp==0.
  - If iw_tgt_sr_we and iw_tgt_sr<SR_REGS, then sr[iw_tgt_sr] <= iw_result. Out-of-range SR writes are dropped silently.
  - GP and SR writes in the same cycle are independent and both occur.
  - The HALT instruction's own writes are committed.
- In HALTED: all writes suppressed; counter frozen.
- Retire counter:
  - +1 per rising edge in RUN with iw_opc != OPC_NOP; HALT counts.
  - Wraps modulo 2**`SIZE_DATA (all-ones → 0).
- Read ports, each evaluated independently:
  - If ZERO_R0=1 and addr==0: data is 0.
  - Else if in RUN, iw_tgt_gp_we=1 and iw_tgt_gp==addr: data is iw_result (bypass).
  - Else: data is gp[addr].
  - ow_sr uses the same bypass rule against iw_tgt_sr/iw_tgt_sr_we; out-of-range index reads 0.
- Latency:
  - A write is visible on read ports combinationally in the same cycle (bypass), and from the register file from the next cycle onward.
  - ow_retired and ow_halted update 1 cycle after the retiring edge's inputs.

Optional Feature:
Macro: DIAD_WB_TRACE_EN
- Defined:
  - ow_trc_valid is registered, set to 1 for one cycle per counted (non-NOP, RUN) retirement.
  - ow_trc_pc and ow_trc_data hold that instruction's iw_pc and iw_result.
  - When ow_trc_valid=0, ow_trc_pc and ow_trc_data hold their previous values.
- Undefined: trace ports remain present and are tied to 0; no trace registers are synthesized.

Test Plan:
1. Reset, then assert iw_rst_n=1 → ow_retired=0, ow_halted=0, ow_rd_a/ow_rd_b read 0 for all addresses 0..15.
2. Write gp[5]=0x00A5A5 with iw_rd_a_addr=5 in the same cycle → ow_rd_a=0x00A5A5 that cycle (bypass) and in every following cycle with no write to 5.
3. ZERO_R0=1, write gp[0]=0x123456 → ow_rd_a with addr 0 reads 0 that cycle and afterwards; ow_retired increments by 1.
4. Feed 3 non-NOP, 2 OPC_NOP, then OPC_HALT writing gp[2]=7, then 4 more writes → ow_retired=4, ow_halted=1, gp[2]=7, the later writes are absent, and the count stays frozen.
5. Preload ow_retired to all-ones via 2**`SIZE_DATA-1 retirements, or force it in simulation; retire 1 more → ow_retired=0.
6. With DIAD_WB_TRACE_EN, retire pc=0x000040 with result=0x000099 → one cycle later ow_trc_valid=1, ow_trc_pc=0x000040, ow_trc_data=0x000099. A NOP that follows → ow_trc_valid=0.
